// File: rtl/mac_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mac_seq_pkg                                                      |
// | Purpose : Shared types and defaults for mac_operand_sequencer.             |
// |           Holds the sequencer state encoding and the default widths and   |
// |           latency for the MAC that the sequencer drives.                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mac_seq_pkg;

  // Operand/result width of the MAC port.
  localparam int DEFAULT_DW      = 16;
  // Job length counter width; longest job is 2^LEN_W-1 operand pairs.
  localparam int DEFAULT_LEN_W   = 8;
  // Cycles from the last operand on mac_a/mac_b to a valid mac_c.
  localparam int DEFAULT_MAC_LAT = 2;

  // Width needed for a down-counter that is loaded with lat and stops at 1.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a job
    ST_FEED  = 2'd1,  // streaming operand pairs into the MAC
    ST_DRAIN = 2'd2,  // waiting out the MAC result latency
    ST_HOLD  = 2'd3   // presenting the result until it is consumed
  } mac_seq_state_e;

endpackage : mac_seq_pkg
`default_nettype wire

// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mac_operand_sequencer                                            |
// | Purpose : Upstream stage of the INT/FP MAC. Accepts a dot-product job      |
// |           (length, mode), streams operand pairs into the MAC, waits out   |
// |           the MAC latency, captures the accumulator and returns one result |
// |           per job. Jobs never overlap.                                     |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           job_valid/job_ready/job_len/job_mode : job request               |
// |           op_valid/op_ready/op_a/op_b          : operand pair stream       |
// |           mac_a/mac_b/mac_clear/mac_mode        : registered MAC drive     |
// |           mac_c                                 : MAC accumulator output   |
// |           res_valid/res_ready/res_data/res_mode : result return            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int LEN_W   = DEFAULT_LEN_W,
  parameter int MAC_LAT = DEFAULT_MAC_LAT   // must be >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // job request
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_mode,
  // operand stream
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [DW-1:0]    op_a,
  input  logic [DW-1:0]    op_b,
  // MAC drive
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  output logic             mac_clear,
  output logic             mac_mode,
  input  logic [DW-1:0]    mac_c,
  // result
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic             res_mode
);

  localparam int CNT_W = cnt_width(MAC_LAT);

  mac_seq_state_e   r_state;
  mac_seq_state_e   w_next_state;
  logic [LEN_W-1:0] r_remain;
  logic [CNT_W-1:0] r_lat_cnt;
  logic             r_first;

  logic w_job_fire;
  logic w_op_fire;
  logic w_last_op;
  logic w_lat_done;

  // Handshakes are qualified by state so the ready outputs stay purely
  // state-decoded.
  assign w_job_fire = (r_state == ST_IDLE) && job_valid;
  assign w_op_fire  = (r_state == ST_FEED) && op_valid;
  assign w_last_op  = w_op_fire && (r_remain == LEN_W'(1));
  assign w_lat_done = (r_lat_cnt == CNT_W'(1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and ready decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    job_ready    = 1'b0;
    op_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          // A zero-length job skips the MAC entirely and returns zero.
          w_next_state = (job_len != '0) ? ST_FEED : ST_HOLD;
        end
      end
      ST_FEED: begin
        op_ready = 1'b1;
        if (w_last_op) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_lat_done) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remain  <= '0;
      r_lat_cnt <= '0;
      r_first   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clear <= 1'b0;
      mac_mode  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mode  <= 1'b0;
    end else begin
      // res_valid tracks HOLD one-for-one, so it rises with the state change.
      res_valid <= (w_next_state == ST_HOLD);

      case (r_state)
        ST_IDLE: begin
          if (w_job_fire) begin
            r_remain <= job_len;
            mac_mode <= job_mode;
            res_mode <= job_mode;
            r_first  <= 1'b1;
            // Already correct for a zero-length job; overwritten otherwise.
            res_data <= '0;
          end
        end
        ST_FEED: begin
          if (w_op_fire) begin
            mac_a     <= op_a;
            mac_b     <= op_b;
            // The first pair of a job reloads the accumulator, discarding
            // anything left from an earlier or abandoned job.
            mac_clear <= r_first;
            r_first   <= 1'b0;
            r_remain  <= r_remain - LEN_W'(1);
            if (w_last_op) begin
              r_lat_cnt <= CNT_W'(MAC_LAT);
            end
          end else begin
            // Bubble: a zero product leaves the accumulator unchanged.
            mac_a     <= '0;
            mac_b     <= '0;
            mac_clear <= 1'b0;
          end
        end
        ST_DRAIN: begin
          mac_a     <= '0;
          mac_b     <= '0;
          mac_clear <= 1'b0;
          r_lat_cnt <= r_lat_cnt - CNT_W'(1);
          if (w_lat_done) begin
            res_data <= mac_c;
          end
        end
        default: begin
          // ST_HOLD: result and mode held until consumed.
        end
      endcase
    end
  end

endmodule : mac_operand_sequencer
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mac_operand_sequencer                                         |
// | Purpose : Directed self-checking bench for mac_operand_sequencer with a    |
// |           behavioural MAC stub (INT and half-precision FP accumulate).     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mac_operand_sequencer;

  localparam int DW    = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             job_valid;
  logic             job_ready;
  logic [LEN_W-1:0] job_len;
  logic             job_mode;
  logic             op_valid;
  logic             op_ready;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic             mac_clear;
  logic             mac_mode;
  logic [DW-1:0]    mac_c;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_data;
  logic             res_mode;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mac_operand_sequencer #(.DW(DW), .LEN_W(LEN_W), .MAC_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_len   (job_len),
    .job_mode  (job_mode),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clear (mac_clear),
    .mac_mode  (mac_mode),
    .mac_c     (mac_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_mode  (res_mode)
  );

  // ---------------- MAC stub (slave side, latency 2) ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(h[9:0]) * pow2(-24);
    else        m = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  m;
    int   e;
    int   f;
    s = (r < 0.0);
    m = s ? -r : r;
    if (m == 0.0) return {s, 15'd0};
    e = 15;
    while (m >= 2.0)            begin m = m / 2.0; e++; end
    while (m < 1.0 && e > 1)    begin m = m * 2.0; e--; end
    f = $rtoi((m - 1.0) * 1024.0 + 0.5);
    return {s, e[4:0], f[9:0]};
  endfunction

  logic [15:0] acc_int = '0;
  real         acc_fp  = 0.0;

  always @(posedge clk) begin
    if (mac_mode) begin
      if (mac_clear) acc_fp <= h2r(mac_a) * h2r(mac_b);
      else           acc_fp <= acc_fp + h2r(mac_a) * h2r(mac_b);
    end else begin
      if (mac_clear) acc_int <= 16'(mac_a * mac_b);
      else           acc_int <= acc_int + 16'(mac_a * mac_b);
    end
  end

  always_comb mac_c = mac_mode ? r2h(acc_fp) : acc_int;

  // ---------------- helpers (stimulus only) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Job handshake; returns in cycle 1 (first cycle after the handshake).
  task automatic start_job(input logic [LEN_W-1:0] len, input logic mode);
    job_valid = 1'b1; job_len = len; job_mode = mode;
    step();
    job_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; job_valid = 0; job_len = '0; job_mode = 0;
    op_valid = 0; op_a = '0; op_b = '0; res_ready = 0;
    step(); step();
    tests++;
    if ({mac_a, mac_b, mac_clear, mac_mode, res_valid, res_data, res_mode, op_ready, job_ready}
        !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL reset: mac_a=%h mac_b=%h clr=%b mode=%b rv=%b rd=%h rm=%b opr=%b jr=%b required all 0 except jr=1",
               mac_a, mac_b, mac_clear, mac_mode, res_valid, res_data, res_mode, op_ready, job_ready);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_int_job();
    logic [15:0] av [3] = '{16'd1, 16'd3, 16'd5};
    logic [15:0] bv [3] = '{16'd2, 16'd4, 16'd6};
    int cyc;
    start_job(8'd3, 1'b0);
    cyc = 1;
    tests++;
    if (op_ready !== 1'b1 || job_ready !== 1'b0) begin
      failed++; $display("FAIL int_ready: op_ready=%b job_ready=%b required 1 0", op_ready, job_ready);
    end
    for (int i = 0; i < 3; i++) begin
      op_valid = 1'b1; op_a = av[i]; op_b = bv[i];
      step(); cyc++;
      tests++;
      if (mac_a !== av[i] || mac_b !== bv[i] || mac_clear !== (i == 0)) begin
        failed++;
        $display("FAIL int_feed[%0d]: a=%h b=%h clr=%b required a=%h b=%h clr=%b",
                 i, mac_a, mac_b, mac_clear, av[i], bv[i], (i == 0));
      end
    end
    op_valid = 1'b0;
    step(); cyc++;
    tests++;
    if (mac_a !== 16'h0 || mac_b !== 16'h0 || mac_clear !== 1'b0 || op_ready !== 1'b0) begin
      failed++;
      $display("FAIL int_drain: a=%h b=%h clr=%b opr=%b required 0 0 0 0", mac_a, mac_b, mac_clear, op_ready);
    end
    while (!res_valid && cyc < 40) begin step(); cyc++; end
    tests++;
    if (cyc !== 6 || res_data !== 16'h002C || res_mode !== 1'b0) begin
      failed++;
      $display("FAIL int_result: cycle=%0d data=%h mode=%b required cycle=6 data=002c mode=0", cyc, res_data, res_mode);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      failed++; $display("FAIL int_done: res_valid=%b job_ready=%b required 0 1", res_valid, job_ready);
    end
  endtask

  task automatic test_fp_job();
    logic [15:0] av [2] = '{16'h3C00, 16'h4000};
    logic [15:0] bv [2] = '{16'h4000, 16'h4000};
    int cyc;
    start_job(8'd2, 1'b1);
    cyc = 1;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_a = av[i]; op_b = bv[i];
      step(); cyc++;
    end
    op_valid = 1'b0;
    while (!res_valid && cyc < 40) begin
      tests++;
      if (mac_mode !== 1'b1) begin
        failed++; $display("FAIL fp_mode cycle %0d: mac_mode=%b required 1", cyc, mac_mode);
      end
      step(); cyc++;
    end
    tests++;
    if (cyc !== 5 || res_data !== 16'h4600 || res_mode !== 1'b1) begin
      failed++;
      $display("FAIL fp_result: cycle=%0d data=%h mode=%b required cycle=5 data=4600 mode=1", cyc, res_data, res_mode);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_bubble();
    logic [15:0] av [4] = '{16'd1, 16'd2, 16'd4, 16'd6};
    logic [15:0] bv [4] = '{16'd1, 16'd3, 16'd5, 16'd7};
    int cyc;
    start_job(8'd4, 1'b0);
    cyc = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        op_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
          step(); cyc++;
          tests++;
          if (mac_a !== 16'h0 || mac_b !== 16'h0 || mac_clear !== 1'b0) begin
            failed++;
            $display("FAIL bubble[%0d]: a=%h b=%h clr=%b required 0 0 0", k, mac_a, mac_b, mac_clear);
          end
        end
      end
      op_valid = 1'b1; op_a = av[i]; op_b = bv[i];
      step(); cyc++;
    end
    op_valid = 1'b0;
    while (!res_valid && cyc < 40) begin step(); cyc++; end
    tests++;
    if (cyc !== 9 || res_data !== 16'd69) begin
      failed++;
      $display("FAIL bubble_result: cycle=%0d data=%0d required cycle=9 data=69", cyc, res_data);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    start_job(8'd0, 1'b0);
    tests++;
    if (res_valid !== 1'b1 || res_data !== 16'h0 || op_ready !== 1'b0) begin
      failed++;
      $display("FAIL zero_len: res_valid=%b data=%h op_ready=%b required 1 0000 0", res_valid, res_data, op_ready);
    end
    tests++;
    if (mac_a !== 16'h0 || mac_b !== 16'h0 || mac_clear !== 1'b0) begin
      failed++; $display("FAIL zero_len_mac: a=%h b=%h clr=%b required 0 0 0", mac_a, mac_b, mac_clear);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_job(8'd1, 1'b0);
    op_valid = 1'b1; op_a = 16'd3; op_b = 16'd3;
    step();
    op_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 40) begin step(); cyc++; end
    job_valid = 1'b1; job_len = 8'd1; job_mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (res_valid !== 1'b1 || res_data !== 16'd9 || job_ready !== 1'b0) begin
        failed++;
        $display("FAIL backpressure[%0d]: rv=%b data=%0d jr=%b required 1 9 0", k, res_valid, res_data, job_ready);
      end
      step();
    end
    job_valid = 1'b0;
    res_ready = 1'b1; step(); res_ready = 1'b0;
    tests++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      failed++; $display("FAIL b2b_ready: jr=%b rv=%b required 1 0", job_ready, res_valid);
    end
    start_job(8'd1, 1'b0);
    op_valid = 1'b1; op_a = 16'd2; op_b = 16'd5;
    step();
    op_valid = 1'b0;
    tests++;
    if (mac_clear !== 1'b1) begin
      failed++; $display("FAIL b2b_clear: mac_clear=%b required 1", mac_clear);
    end
    cyc = 0;
    while (!res_valid && cyc < 40) begin step(); cyc++; end
    tests++;
    if (res_valid !== 1'b1 || res_data !== 16'd10) begin
      failed++; $display("FAIL b2b_result: rv=%b data=%0d required 1 10", res_valid, res_data);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_reset_midjob();
    int cyc;
    start_job(8'd3, 1'b1);
    op_valid = 1'b1; op_a = 16'h4000; op_b = 16'h4000;
    step();
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mac_a, mac_b, mac_clear, mac_mode, res_valid, res_data, res_mode, op_ready, job_ready}
        !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL midjob_reset: a=%h b=%h clr=%b mode=%b rv=%b rd=%h rm=%b opr=%b jr=%b required all 0 except jr=1",
               mac_a, mac_b, mac_clear, mac_mode, res_valid, res_data, res_mode, op_ready, job_ready);
    end
    #2 rst_n = 1'b1;
    step();
    start_job(8'd1, 1'b0);
    op_valid = 1'b1; op_a = 16'd7; op_b = 16'd7;
    step();
    op_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 40) begin step(); cyc++; end
    tests++;
    if (res_valid !== 1'b1 || res_data !== 16'd49 || res_mode !== 1'b0) begin
      failed++;
      $display("FAIL after_reset_result: rv=%b data=%0d mode=%b required 1 49 0", res_valid, res_data, res_mode);
    end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_int_job();
    test_fp_job();
    test_bubble();
    test_zero_len();
    test_back_to_back();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_mac_operand_sequencer
`default_nettype wire

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Upstream stage of the INT/FP MAC. Accepts dot-product jobs (length, mode) and a stream of 16-bit operand pairs over valid/ready, drives the MAC's `a`, `b`, `clear` and `mode` inputs, and waits out the MAC result latency. It then captures `c` and returns one result per job over valid/ready. The MAC itself is untouched; this block is its only driver.

## Interface
- `DW`, 16: operand and result width; matches the MAC port width.
- `LEN_W`, 8: job length counter width; maximum job length is 2^LEN_W-1.
- `MAC_LAT`, 2: cycles from the last operand presented on `mac_a`/`mac_b` to a valid `mac_c`; must be ≥1.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `job_valid` in 1: job request valid.
- `job_ready` out 1: job accepted when both signals are high.
- `job_len` in LEN_W: number of operand pairs in the job.
- `job_mode` in 1: 0 = INT, 1 = FP; held for the whole job.
- `op_valid` in 1: operand pair valid.
- `op_ready` out 1: operand pair accepted when both signals are high.
- `op_a`, `op_b` in DW each: operand pair.
- `mac_a`, `mac_b` out DW each: to MAC `a`, `b`.
- `mac_clear` out 1: to MAC `clear`.
- `mac_mode` out 1: to MAC `mode`.
- `mac_c` in DW: from MAC `c`.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumed when both signals are high.
- `res_data` out DW: dot-product result.
- `res_mode` out 1: mode of the job that produced `res_data`.

## Operation
- MAC contract:
  - A cycle with `clear=1` loads the accumulator with `a*b`.
  - A cycle with `clear=0` adds `a*b` to the accumulator.
  - `a=b=0` contributes zero.
- FSM states: IDLE, FEED, DRAIN, HOLD.
- IDLE:
  - `job_ready=1`, `op_ready=0`.
  - On job handshake: latch `job_len` into `remain` and `job_mode` into `mac_mode`/`res_mode`; set the `first` flag.
  - `job_len≠0` → FEED.
  - `job_len=0` → HOLD with `res_data=0`; the MAC is not touched.
- FEED:
  - `op_ready=1`.
  - On operand handshake: register `op_a`/`op_b` onto `mac_a`/`mac_b`; `mac_clear` = `first`; clear `first`; decrement `remain`.
  - No handshake (bubble): `mac_a=mac_b=0`, `mac_clear=0`. In FP mode a bubble may turn a −0 accumulator into +0; this is accepted.
  - Handshake with `remain==1` → DRAIN and load the latency counter with `MAC_LAT`.
- DRAIN:
  - `op_ready=0`; `mac_a`/`mac_b`/`mac_clear` return to 0 on the first DRAIN cycle.
  - Counter decrements each cycle.
  - When the counter reaches 1, capture `mac_c` into `res_data` and go to HOLD.
- HOLD:
  - `res_valid=1`; `res_data`/`res_mode` are stable.
  - On result handshake → IDLE.
- `job_ready` and `op_ready` are combinational from state only, never from `*_valid`.
- All `mac_*`, `res_*` and `res_valid` are registered outputs.

## Timing
- Reset values:
  - state IDLE.
  - `mac_a=mac_b=0`, `mac_clear=0`, `mac_mode=0`.
  - `res_valid=0`, `res_data=0`, `res_mode=0`.
  - `op_ready=0`, `job_ready=1`.
- Operand handshake at edge E → value appears on `mac_a`/`mac_b` in the cycle after E.
- Last operand on `mac_*` in cycle T → `mac_c` sampled at the end of cycle T+MAC_LAT−1 → `res_valid` high from cycle T+MAC_LAT.
- No-bubble latency, job handshake to `res_valid`: 1 + N + MAC_LAT cycles.
- Back-to-back jobs: the next `job_ready` comes the cycle after the result handshake. No overlap between jobs.
- `res_valid` stays asserted with stable data until `res_ready`; backpressure never drops a result.
- `mac_mode` changes only on a job handshake, never mid-job.
- `remain` width is LEN_W; no wrap, because the decrement happens only while `remain≥1`.
- Reset asserted mid-job:
  - The job is abandoned and no result is produced.
  - Outputs go to reset values asynchronously.
  - The MAC accumulator is not cleared here; the next job's `first` operand clears it.

## Structure
- `mac_seq_pkg` holds:
  - the state enum `mac_seq_state_e`;
  - `DW` default 16;
  - localparam `CNT_W = $clog2(MAC_LAT+1)` pattern.
- No sub-modules: a single module holding the FSM, the `remain` counter, the latency counter and the output registers.
- Bench binds `mac_*` to the existing MAC interface's slave side.

## Test plan
- INT job, `len=3`, pairs (1,2),(3,4),(5,6), stub MAC with MAC_LAT=2 → `mac_clear=1` only on the first pair; `res_data=0x002C` (44), `res_mode=0`; `res_valid` at cycle 1+3+2.
- FP job, `len=2`, pairs (0x3C00,0x4000),(0x4000,0x4000) → `res_data=0x4600` (6.0), `res_mode=1`; `mac_mode=1` for the whole job.
- INT `len=4` with `op_valid` low for 2 cycles mid-stream → bubbles drive `a=b=0`, `clear=0`; result equals the no-bubble result.
- `job_len=0` → `res_valid` the cycle after the job handshake with `res_data=0`; `mac_*` stay 0.
- `res_ready` held low 5 cycles → `res_valid`/`res_data` stable; `job_ready=0` until the handshake; a second job then starts with `mac_clear=1`.
- `rst_n` pulsed low mid-FEED → all outputs at reset values immediately; the next job with `len=1`, pair (7,7), returns 49.
